// File: rtl/lc3_mem_arbiter.sv
// LC-3 main-memory arbiter: shares one fixed-latency memory port between the
// CPU memory interface (MAR/MDR/MIO_EN/R_W) and a debug/loader port.
// One access in flight at a time. Contention is resolved round-robin, and each
// completed access returns a one-cycle ready pulse (the CPU's R signal).
// MEM_LAT must lie in 1..15 so that the access counter fits in 4 bits.
module lc3_mem_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_rdy,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_rdy,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  typedef enum logic {
    G_CPU = 1'b0,
    G_DBG = 1'b1
  } grant_e;

  localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

  state_e            state_q, state_d;
  grant_e            owner_q, owner_d;
  grant_e            last_q, last_d;
  grant_e            grant;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;

  // Arbitration choice: a lone requester wins; under contention the port that
  // was not served last wins.
  always_comb begin
    grant = G_CPU;
    if (cpu_req && dbg_req) begin
      grant = (last_q == G_CPU) ? G_DBG : G_CPU;
    end else if (dbg_req) begin
      grant = G_DBG;
    end
  end

  // Next-state logic: grant in IDLE, count the access down in BUSY, and
  // pulse ready in DONE.
  always_comb begin
    // NOTE: every variable gets its hold value first, so no path through the
    // case statement can leave one unassigned and infer a latch.
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    cpu_rdata_d = cpu_rdata_q;
    dbg_rdata_d = dbg_rdata_q;

    unique case (state_q)
      S_IDLE: begin
        if (cpu_req || dbg_req) begin
          owner_d = grant;
          last_d  = grant;
          cnt_d   = CNT_INIT;
          state_d = S_BUSY;
          if (grant == G_DBG) begin
            we_d    = dbg_we;
            addr_d  = dbg_addr;
            wdata_d = dbg_wdata;
          end else begin
            we_d    = cpu_we;
            addr_d  = cpu_addr;
            wdata_d = cpu_wdata;
          end
        end
      end
      S_BUSY: begin
        if (cnt_q == 4'd0) begin
          // Memory read data is valid in the last access cycle only.
          if (!we_q) begin
            if (owner_q == G_DBG) dbg_rdata_d = mem_rdata;
            else                  cpu_rdata_d = mem_rdata;
          end
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and latched-request registers. Reset aborts any in-flight access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: every register here has a defined reset value, so all outputs
      // are 0 while reset is held, including the read-data holding registers.
      state_q     <= S_IDLE;
      owner_q     <= G_CPU;
      last_q      <= G_DBG;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
    end else begin
      // NOTE: non-blocking updates let every register sample the old values
      // together, which models real flip-flops.
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      cpu_rdata_q <= cpu_rdata_d;
      dbg_rdata_q <= dbg_rdata_d;
    end
  end

  // Outputs decode registered state only, so there is no path from the
  // request inputs. The memory bus is held at zero outside BUSY.
  assign mem_en    = (state_q == S_BUSY);
  assign mem_we    = mem_en && we_q;
  assign mem_addr  = mem_en ? addr_q  : '0;
  assign mem_wdata = mem_en ? wdata_q : '0;
  assign cpu_rdy   = (state_q == S_DONE) && (owner_q == G_CPU);
  assign dbg_rdy   = (state_q == S_DONE) && (owner_q == G_DBG);
  assign cpu_rdata = cpu_rdata_q;
  assign dbg_rdata = dbg_rdata_q;

endmodule

// File: tb/tb_lc3_mem_arbiter.sv
// Testbench for lc3_mem_arbiter. Three instances (MEM_LAT = 2, 1, 15) share
// the requester stimulus. Each instance has its own behavioural memory.
// A transaction-phase model predicts every output, and directed literal
// checks pin the model itself.
module tb_lc3_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we, dbg_req, dbg_we;
  logic [15:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;

  logic        cpu_rdy   [3];
  logic        dbg_rdy   [3];
  logic        mem_en    [3];
  logic        mem_we    [3];
  logic [15:0] cpu_rdata [3];
  logic [15:0] dbg_rdata [3];
  logic [15:0] mem_addr  [3];
  logic [15:0] mem_wdata [3];
  logic [15:0] mem_rdata [3];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  lc3_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(2)) dut0 (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdy(cpu_rdy[0]), .cpu_rdata(cpu_rdata[0]),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_rdy(dbg_rdy[0]), .dbg_rdata(dbg_rdata[0]),
    .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]),
    .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0]));

  lc3_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(1)) dut1 (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdy(cpu_rdy[1]), .cpu_rdata(cpu_rdata[1]),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_rdy(dbg_rdy[1]), .dbg_rdata(dbg_rdata[1]),
    .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]),
    .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1]));

  lc3_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(15)) dut2 (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdy(cpu_rdy[2]), .cpu_rdata(cpu_rdata[2]),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_rdy(dbg_rdy[2]), .dbg_rdata(dbg_rdata[2]),
    .mem_en(mem_en[2]), .mem_we(mem_we[2]), .mem_addr(mem_addr[2]),
    .mem_wdata(mem_wdata[2]), .mem_rdata(mem_rdata[2]));

  function automatic int lat_of(input int i);
    return (i == 0) ? 2 : ((i == 1) ? 1 : 15);
  endfunction

  // Initial memory image. Addresses are decoded on their low byte, and word 0
  // (address 0x3000 in the tests) holds 0x1234.
  function automatic logic [15:0] init_word(input int a);
    return (a == 0) ? 16'h1234 : (16'(a) * 16'h0101) ^ 16'h5A5A;
  endfunction

  // Arbitration rule: 1 selects debug, 0 selects CPU.
  function automatic bit pick_dbg(input bit c, input bit d, input bit last_dbg);
    return (c && d) ? !last_dbg : d;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural memories, one per instance.
  logic [15:0] env_mem [3][256];

  always_comb begin
    for (int i = 0; i < 3; i++)
      mem_rdata[i] = mem_en[i] ? env_mem[i][mem_addr[i][7:0]] : 16'h0;
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++)
        for (int a = 0; a < 256; a++) env_mem[i][a] <= init_word(a);
    end else begin
      for (int i = 0; i < 3; i++)
        if (mem_en[i] && mem_we[i]) env_mem[i][mem_addr[i][7:0]] <= mem_wdata[i];
    end
  end

  // Transaction model. ph counts cycles since the grant edge:
  // 0 = idle, 1..LAT = access in progress, LAT+1 = ready pulse.
  int          ph     [3];
  bit          own    [3];
  bit          last_g [3];
  bit          m_we   [3];
  logic [15:0] m_addr [3];
  logic [15:0] m_wd   [3];
  logic [15:0] m_crd  [3];
  logic [15:0] m_drd  [3];
  logic [15:0] m_mem  [3][256];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        ph[i] <= 0; own[i] <= 1'b0; last_g[i] <= 1'b1; m_we[i] <= 1'b0;
        m_addr[i] <= '0; m_wd[i] <= '0; m_crd[i] <= '0; m_drd[i] <= '0;
        for (int a = 0; a < 256; a++) m_mem[i][a] <= init_word(a);
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (ph[i] == 0) begin
          if (cpu_req || dbg_req) begin
            own[i]    <= pick_dbg(cpu_req, dbg_req, last_g[i]);
            last_g[i] <= pick_dbg(cpu_req, dbg_req, last_g[i]);
            if (pick_dbg(cpu_req, dbg_req, last_g[i])) begin
              m_we[i] <= dbg_we; m_addr[i] <= dbg_addr; m_wd[i] <= dbg_wdata;
            end else begin
              m_we[i] <= cpu_we; m_addr[i] <= cpu_addr; m_wd[i] <= cpu_wdata;
            end
            ph[i] <= 1;
          end
        end else if (ph[i] <= lat_of(i)) begin
          if (ph[i] == lat_of(i)) begin
            if (m_we[i])     m_mem[i][m_addr[i][7:0]] <= m_wd[i];
            else if (own[i]) m_drd[i] <= m_mem[i][m_addr[i][7:0]];
            else             m_crd[i] <= m_mem[i][m_addr[i][7:0]];
          end
          ph[i] <= ph[i] + 1;
        end else begin
          ph[i] <= 0;
        end
      end
    end
  end

  // Cycle-by-cycle comparison against the model on the falling edge.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      bit exp_en, exp_cr, exp_dr;
      exp_en = (ph[i] >= 1) && (ph[i] <= lat_of(i));
      exp_cr = (ph[i] == lat_of(i) + 1) && !own[i];
      exp_dr = (ph[i] == lat_of(i) + 1) && own[i];
      check($sformatf("d%0d_mem_en", i), 32'(mem_en[i]), 32'(exp_en));
      check($sformatf("d%0d_mem_we", i), 32'(mem_we[i]), 32'(exp_en && m_we[i]));
      check($sformatf("d%0d_cpu_rdy", i), 32'(cpu_rdy[i]), 32'(exp_cr));
      check($sformatf("d%0d_dbg_rdy", i), 32'(dbg_rdy[i]), 32'(exp_dr));
      if (exp_en) begin
        check($sformatf("d%0d_mem_addr", i), 32'(mem_addr[i]), 32'(m_addr[i]));
        check($sformatf("d%0d_mem_wdata", i), 32'(mem_wdata[i]), 32'(m_wd[i]));
      end
      if (exp_cr && !m_we[i]) check($sformatf("d%0d_cpu_rdata", i), 32'(cpu_rdata[i]), 32'(m_crd[i]));
      if (exp_dr && !m_we[i]) check($sformatf("d%0d_dbg_rdata", i), 32'(dbg_rdata[i]), 32'(m_drd[i]));
    end
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) next();
  endtask

  // One access from the chosen port, observed on the MEM_LAT=2 instance.
  // lat is the cycle index of the ready pulse counted from the request cycle.
  task automatic run_access(input bit dbg, input bit we, input logic [15:0] a,
                            input logic [15:0] d, output int lat, output int en_n,
                            output int we_n, output logic [15:0] rd);
    lat = -1; en_n = 0; we_n = 0; rd = '0;
    if (dbg) begin dbg_req = 1'b1; dbg_we = we; dbg_addr = a; dbg_wdata = d; end
    else     begin cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d; end
    for (int k = 1; k <= 30; k++) begin
      next();
      en_n += int'(mem_en[0]);
      we_n += int'(mem_we[0]);
      if (dbg ? dbg_rdy[0] : cpu_rdy[0]) begin
        lat = k;
        rd  = dbg ? dbg_rdata[0] : cpu_rdata[0];
        break;
      end
    end
    cpu_req = 1'b0;
    dbg_req = 1'b0;
  endtask

  int          lat, en_n, we_n;
  logic [15:0] rd;
  int          c_first, d_first, c_cnt, d_cnt;
  int          en_cnt [3];
  int          rdy_at [3];

  initial begin
    rst = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
    idle(3);
    rst = 1'b0;
    check("reset_mem_en", 32'(mem_en[0]), 32'd0);
    check("reset_cpu_rdy", 32'(cpu_rdy[0]), 32'd0);
    check("reset_cpu_rdata", 32'(cpu_rdata[0]), 32'd0);
    check("reset_mem_addr", 32'(mem_addr[0]), 32'd0);

    // Both ports request from reset: CPU first, then alternating, 4-cycle period.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h3001;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 16'h3002;
    c_first = 0; d_first = 0; c_cnt = 0; d_cnt = 0;
    for (int k = 1; k <= 16; k++) begin
      next();
      if (cpu_rdy[0]) begin c_cnt++; if (c_first == 0) c_first = k; end
      if (dbg_rdy[0]) begin d_cnt++; if (d_first == 0) d_first = k; end
    end
    cpu_req = 1'b0; dbg_req = 1'b0;
    check("alt_cpu_first", 32'(c_first), 32'd3);
    check("alt_dbg_first", 32'(d_first), 32'd7);
    check("alt_cpu_count", 32'(c_cnt), 32'd2);
    check("alt_dbg_count", 32'(d_cnt), 32'd2);
    idle(40);

    // CPU read of 0x3000.
    run_access(1'b0, 1'b0, 16'h3000, 16'h0000, lat, en_n, we_n, rd);
    check("cpu_rd_latency", 32'(lat), 32'd3);
    check("cpu_rd_en_cycles", 32'(en_n), 32'd2);
    check("cpu_rd_data", 32'(rd), 32'h1234);
    idle(2);

    // Debug write of 0xBEEF to 0x0005, then CPU reads it back.
    run_access(1'b1, 1'b1, 16'h0005, 16'hBEEF, lat, en_n, we_n, rd);
    check("dbg_wr_latency", 32'(lat), 32'd3);
    check("dbg_wr_we_cycles", 32'(we_n), 32'd2);
    idle(2);
    run_access(1'b0, 1'b0, 16'h0005, 16'h0000, lat, en_n, we_n, rd);
    check("cpu_readback", 32'(rd), 32'hBEEF);
    check("cpu_readback_we", 32'(we_n), 32'd0);
    idle(2);

    // CPU request dropped during BUSY: the access still completes once.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h3010;
    c_cnt = 0;
    for (int k = 1; k <= 8; k++) begin
      next();
      if (k == 1) cpu_req = 1'b0;
      if (cpu_rdy[0]) c_cnt++;
    end
    check("drop_rdy_count", 32'(c_cnt), 32'd1);
    check("drop_back_idle", 32'(mem_en[0]), 32'd0);
    idle(40);

    // Single CPU read seen by all three latencies at once.
    for (int i = 0; i < 3; i++) begin en_cnt[i] = 0; rdy_at[i] = 0; end
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h3000;
    for (int k = 1; k <= 20; k++) begin
      next();
      if (k == 1) cpu_req = 1'b0;
      for (int i = 0; i < 3; i++) begin
        en_cnt[i] += int'(mem_en[i]);
        if (cpu_rdy[i] && rdy_at[i] == 0) rdy_at[i] = k;
      end
    end
    check("lat1_busy_cycles", 32'(en_cnt[1]), 32'd1);
    check("lat1_rdy_latency", 32'(rdy_at[1]), 32'd2);
    check("lat15_busy_cycles", 32'(en_cnt[2]), 32'd15);
    check("lat15_rdy_latency", 32'(rdy_at[2]), 32'd16);
    check("lat2_busy_cycles", 32'(en_cnt[0]), 32'd2);
    idle(4);

    // Asynchronous reset in the middle of BUSY.
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h3020; cpu_wdata = 16'h1111;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 16'h3021;
    next();
    #2 rst = 1'b1;
    #1;
    check("async_rst_mem_en", 32'(mem_en[0]), 32'd0);
    check("async_rst_mem_we", 32'(mem_we[0]), 32'd0);
    check("async_rst_cpu_rdy", 32'(cpu_rdy[0]), 32'd0);
    check("async_rst_dbg_rdy", 32'(dbg_rdy[0]), 32'd0);
    next();
    rst = 1'b0;
    c_first = 0; d_first = 0;
    for (int k = 1; k <= 12; k++) begin
      next();
      if (cpu_rdy[0] && c_first == 0) c_first = k;
      if (dbg_rdy[0] && d_first == 0) d_first = k;
      if (k == 7) begin cpu_req = 1'b0; dbg_req = 1'b0; end
    end
    check("post_rst_cpu_first", 32'(c_first), 32'd3);
    check("post_rst_dbg_next", 32'(d_first), 32'd7);
    idle(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
